// File: rtl/spi_ctrl_regs_if.sv
// Master-side link of the SPI control front-end: start/busy handshake, shadowed
// transfer configuration and the MOSI/MISO data words.
interface spi_ctrl_regs_if #(
   parameter int unsigned DATA_W = 32
);
   logic              start_o;
   logic              busy_i;
   logic [1:0]        spi_mode_o;
   logic [1:0]        sck_speed_o;
   logic [1:0]        word_len_o;
   logic [7:0]        ifg_o;
   logic [7:0]        cs_sck_o;
   logic [7:0]        sck_cs_o;
   logic [DATA_W-1:0] mosi_data_o;
   logic [DATA_W-1:0] miso_data_i;

   // Front-end side: launches transfers and collects the returned word
   modport master (
      output start_o, spi_mode_o, sck_speed_o, word_len_o,
             ifg_o, cs_sck_o, sck_cs_o, mosi_data_o,
      input  busy_i, miso_data_i
   );

   // SPI master core side
   modport slave (
      input  start_o, spi_mode_o, sck_speed_o, word_len_o,
             ifg_o, cs_sck_o, sck_cs_o, mosi_data_o,
      output busy_i, miso_data_i
   );
endinterface

// File: rtl/spi_ctrl_regs.sv
// Buffered SPI control/status front-end: TX/RX FIFOs, config shadowing and start/busy sequencing.
// Optional interrupt output enabled by defining SPI_CTRL_IRQ_EN.
module spi_ctrl_regs #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                        GCLK,
   input  logic                        RST,
   input  logic                        en_i,
   input  logic                        flush_i,
   input  logic [1:0]                  spi_mode_i,
   input  logic [1:0]                  sck_speed_i,
   input  logic [1:0]                  word_len_i,
   input  logic [7:0]                  ifg_i,
   input  logic [7:0]                  cs_sck_i,
   input  logic [7:0]                  sck_cs_i,
   input  logic                        tx_push_i,
   input  logic [DATA_W-1:0]           tx_data_i,
   input  logic                        rx_pop_i,
   output logic [DATA_W-1:0]           rx_data_o,
   output logic                        tx_full_o,
   output logic                        rx_empty_o,
   output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
   output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
   output logic                        tx_ovf_o,
   output logic                        rx_ovf_o,
   output logic                        start_err_o,
   output logic                        busy_o,
   output logic                        irq_o,
   spi_ctrl_regs_if.master             m_if
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [3:0] WAIT_LAST = 4'd14;

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_XFER, S_STORE
   } state_t;

   state_t r_state, w_state_nxt;

   logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
   logic [LVL_W-1:0]  r_tx_lvl, r_rx_lvl;
   logic              r_tx_full, r_rx_empty;
   logic [DATA_W-1:0] r_rx_head;
   logic              r_tx_ovf, r_rx_ovf, r_start_err;
   logic              r_start, r_busy;
   logic [3:0]        r_wait_cnt;
   logic [DATA_W-1:0] r_cap;
   logic [1:0]        r_spi_mode, r_sck_speed, r_word_len;
   logic [7:0]        r_ifg, r_cs_sck, r_sck_cs;
   logic [DATA_W-1:0] r_mosi;

   logic              w_tx_pop, w_capture, w_rx_push, w_timeout;
   logic              w_tx_do_push, w_tx_drop;
   logic              w_rx_do_pop, w_rx_do_push, w_rx_drop;
   logic [LVL_W-1:0]  w_tx_lvl_nxt, w_rx_lvl_nxt;
   logic [PTR_W-1:0]  w_rx_rd_nxt;
   logic [DATA_W-1:0] w_rx_head_nxt;
   logic [DATA_W-1:0] w_len_mask;

   always_ff @(posedge GCLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_pop    = 1'b0;
      w_capture   = 1'b0;
      w_rx_push   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en_i && !flush_i && (r_tx_lvl != '0)) begin
               w_tx_pop    = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: w_state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (m_if.busy_i) begin
               w_state_nxt = S_XFER;
            end else if (r_wait_cnt == WAIT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_XFER: begin
            if (!m_if.busy_i) begin
               w_capture   = 1'b1;
               w_state_nxt = S_STORE;
            end
         end
         S_STORE: begin
            w_rx_push   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Byte-granular mask for the effective word length of the launched transfer
   always_comb begin
      w_len_mask = '0;
      for (int unsigned i = 0; i < DATA_W; i++)
         w_len_mask[i] = ((i / 32'd8) <= 32'(r_word_len));
   end

   // FIFO bookkeeping; flush overrides any same-cycle push or pop
   always_comb begin
      w_tx_do_push = !flush_i && tx_push_i && ((r_tx_lvl != LVL_FULL) || w_tx_pop);
      w_tx_drop    = !flush_i && tx_push_i && (r_tx_lvl == LVL_FULL) && !w_tx_pop;
      w_rx_do_pop  = !flush_i && rx_pop_i && (r_rx_lvl != '0);
      w_rx_do_push = !flush_i && w_rx_push && ((r_rx_lvl != LVL_FULL) || w_rx_do_pop);
      w_rx_drop    = !flush_i && w_rx_push && (r_rx_lvl == LVL_FULL) && !w_rx_do_pop;
      w_tx_lvl_nxt = flush_i ? '0
                   : r_tx_lvl + LVL_W'(w_tx_do_push) - LVL_W'(w_tx_pop);
      w_rx_lvl_nxt = flush_i ? '0
                   : r_rx_lvl + LVL_W'(w_rx_do_push) - LVL_W'(w_rx_do_pop);
      w_rx_rd_nxt  = flush_i ? '0 : r_rx_rd + PTR_W'(w_rx_do_pop);
   end

   // Next RX head word; a push into the slot that becomes the head is forwarded
   always_comb begin
      w_rx_head_nxt = '0;
      if (w_rx_lvl_nxt != '0) begin
         if (w_rx_do_push && (r_rx_wr == w_rx_rd_nxt)) w_rx_head_nxt = r_cap;
         else                                           w_rx_head_nxt = r_rx_mem[w_rx_rd_nxt];
      end
   end

   always_ff @(posedge GCLK) begin
      if (w_tx_do_push) r_tx_mem[r_tx_wr] <= tx_data_i;
      if (w_rx_do_push) r_rx_mem[r_rx_wr] <= r_cap;
   end

   always_ff @(posedge GCLK) begin
      if (RST) begin
         r_tx_wr     <= '0;
         r_tx_rd     <= '0;
         r_rx_wr     <= '0;
         r_rx_rd     <= '0;
         r_tx_lvl    <= '0;
         r_rx_lvl    <= '0;
         r_tx_full   <= 1'b0;
         r_rx_empty  <= 1'b1;
         r_rx_head   <= '0;
         r_tx_ovf    <= 1'b0;
         r_rx_ovf    <= 1'b0;
         r_start_err <= 1'b0;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_wait_cnt  <= '0;
         r_cap       <= '0;
         r_spi_mode  <= '0;
         r_sck_speed <= '0;
         r_word_len  <= '0;
         r_ifg       <= '0;
         r_cs_sck    <= '0;
         r_sck_cs    <= '0;
         r_mosi      <= '0;
      end else begin
         r_start <= w_tx_pop;
         r_busy  <= (w_state_nxt != S_IDLE) || (w_tx_lvl_nxt != '0);

         // Shadow config and MOSI word are captured only at launch
         if (w_tx_pop) begin
            r_spi_mode  <= spi_mode_i;
            r_sck_speed <= sck_speed_i;
            r_word_len  <= word_len_i;
            r_ifg       <= ifg_i;
            r_cs_sck    <= cs_sck_i;
            r_sck_cs    <= sck_cs_i;
            r_mosi      <= r_tx_mem[r_tx_rd];
         end

         if (w_tx_pop)
            r_wait_cnt <= '0;
         else if ((r_state == S_LAUNCH) || (r_state == S_WAIT_BUSY))
            r_wait_cnt <= r_wait_cnt + 4'd1;

         if (w_capture) r_cap <= m_if.miso_data_i & w_len_mask;

         if (flush_i) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
            r_rx_wr <= '0;
         end else begin
            if (w_tx_do_push) r_tx_wr <= r_tx_wr + PTR_W'(1);
            if (w_tx_pop)     r_tx_rd <= r_tx_rd + PTR_W'(1);
            if (w_rx_do_push) r_rx_wr <= r_rx_wr + PTR_W'(1);
         end
         r_rx_rd    <= w_rx_rd_nxt;
         r_tx_lvl   <= w_tx_lvl_nxt;
         r_rx_lvl   <= w_rx_lvl_nxt;
         r_tx_full  <= (w_tx_lvl_nxt == LVL_FULL);
         r_rx_empty <= (w_rx_lvl_nxt == '0);
         r_rx_head  <= w_rx_head_nxt;

         if (flush_i) begin
            r_tx_ovf    <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_start_err <= 1'b0;
         end else begin
            if (w_tx_drop) r_tx_ovf    <= 1'b1;
            if (w_rx_drop) r_rx_ovf    <= 1'b1;
            if (w_timeout) r_start_err <= 1'b1;
         end
      end
   end

`ifdef SPI_CTRL_IRQ_EN
   logic r_irq;

   // Raised while idle with nothing queued, or while any error is pending
   always_ff @(posedge GCLK) begin
      if (RST) r_irq <= 1'b0;
      else     r_irq <= ((r_tx_lvl == '0) && (r_state == S_IDLE))
                        || r_tx_ovf || r_rx_ovf || r_start_err;
   end
   assign irq_o = r_irq;
`else
   assign irq_o = 1'b0;
`endif

   assign rx_data_o   = r_rx_head;
   assign tx_full_o   = r_tx_full;
   assign rx_empty_o  = r_rx_empty;
   assign tx_level_o  = r_tx_lvl;
   assign rx_level_o  = r_rx_lvl;
   assign tx_ovf_o    = r_tx_ovf;
   assign rx_ovf_o    = r_rx_ovf;
   assign start_err_o = r_start_err;
   assign busy_o      = r_busy;

   assign m_if.start_o     = r_start;
   assign m_if.spi_mode_o  = r_spi_mode;
   assign m_if.sck_speed_o = r_sck_speed;
   assign m_if.word_len_o  = r_word_len;
   assign m_if.ifg_o       = r_ifg;
   assign m_if.cs_sck_o    = r_cs_sck;
   assign m_if.sck_cs_o    = r_sck_cs;
   assign m_if.mosi_data_o = r_mosi;
endmodule

// File: tb/tb_spi_ctrl_regs.sv
// Bench for spi_ctrl_regs: behavioural SPI master plus an RX scoreboard of expected words.
module tb_spi_ctrl_regs;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

`ifdef SPI_CTRL_IRQ_EN
   localparam logic EXP_IRQ_IDLE = 1'b1;
`else
   localparam logic EXP_IRQ_IDLE = 1'b0;
`endif

   logic              GCLK = 1'b0;
   logic              RST;
   logic              en_i, flush_i, tx_push_i, rx_pop_i;
   logic [1:0]        spi_mode_i, sck_speed_i, word_len_i;
   logic [7:0]        ifg_i, cs_sck_i, sck_cs_i;
   logic [DATA_W-1:0] tx_data_i, rx_data_o;
   logic              tx_full_o, rx_empty_o, tx_ovf_o, rx_ovf_o, start_err_o, busy_o, irq_o;
   logic [LVL_W-1:0]  tx_level_o, rx_level_o;

   spi_ctrl_regs_if #(.DATA_W(DATA_W)) m_if ();

   spi_ctrl_regs #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
      .GCLK(GCLK), .RST(RST), .en_i(en_i), .flush_i(flush_i),
      .spi_mode_i(spi_mode_i), .sck_speed_i(sck_speed_i), .word_len_i(word_len_i),
      .ifg_i(ifg_i), .cs_sck_i(cs_sck_i), .sck_cs_i(sck_cs_i),
      .tx_push_i(tx_push_i), .tx_data_i(tx_data_i), .rx_pop_i(rx_pop_i),
      .rx_data_o(rx_data_o), .tx_full_o(tx_full_o), .rx_empty_o(rx_empty_o),
      .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
      .tx_ovf_o(tx_ovf_o), .rx_ovf_o(rx_ovf_o), .start_err_o(start_err_o),
      .busy_o(busy_o), .irq_o(irq_o), .m_if(m_if)
   );

   always #5 GCLK = ~GCLK;

   int cyc = 0;
   always @(posedge GCLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] miso_q [$];
   logic [31:0] sb_q [$];
   bit model_en = 1'b1;
   int hold_cyc = 3;
   int fall_cyc = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mask_exp(input logic [31:0] v, input logic [1:0] wl);
      logic [63:0] m;
      m = (64'd1 << (8 * (int'(wl) + 1))) - 64'd1;
      return v & m[31:0];
   endfunction

   // Behavioural SPI master: busy follows start, returns the next queued MISO word
   initial begin
      m_if.busy_i      = 1'b0;
      m_if.miso_data_i = '0;
      forever begin
         @(negedge GCLK);
         if (m_if.start_o && model_en && !RST) begin
            m_if.busy_i = 1'b1;
            for (int k = 0; k < hold_cyc; k++) begin
               @(negedge GCLK);
               if (RST) break;
            end
            m_if.busy_i      = 1'b0;
            m_if.miso_data_i = (miso_q.size() != 0) ? miso_q.pop_front() : 32'h0;
            fall_cyc         = cyc;
         end
      end
   end

   task automatic push_tx(input logic [31:0] d, input logic [31:0] miso, input bit xfer, input bit keep);
      tx_push_i = 1'b1;
      tx_data_i = d;
      if (xfer) miso_q.push_back(miso);
      if (keep) sb_q.push_back(mask_exp(miso, word_len_i));
      @(negedge GCLK);
      tx_push_i = 1'b0;
   endtask

   task automatic drain_rx(input int n);
      logic [31:0] exp;
      for (int i = 0; i < n; i++) begin
         for (int t = 0; t < 64 && rx_empty_o; t++) @(negedge GCLK);
         exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
         check_eq("rx_data", 64'(rx_data_o), 64'(exp));
         rx_pop_i = 1'b1;
         @(negedge GCLK);
         rx_pop_i = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int t = 0; t < 400 && busy_o; t++) @(negedge GCLK);
      check_eq(tag, 64'(busy_o), 64'd0);
   endtask

   task automatic wait_start(input string tag);
      for (int t = 0; t < 32 && !m_if.start_o; t++) @(negedge GCLK);
      check_eq(tag, 64'(m_if.start_o), 64'd1);
   endtask

   task automatic wait_master_busy(input string tag);
      for (int t = 0; t < 32 && !m_if.busy_i; t++) @(negedge GCLK);
      check_eq(tag, 64'(m_if.busy_i), 64'd1);
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      @(negedge GCLK);
      flush_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; en_i = 1'b0; flush_i = 1'b0; tx_push_i = 1'b0; rx_pop_i = 1'b0;
      spi_mode_i = '0; sck_speed_i = '0; word_len_i = '0;
      ifg_i = '0; cs_sck_i = '0; sck_cs_i = '0; tx_data_i = '0;
      repeat (3) @(negedge GCLK);

      // Reset values
      check_eq("rst_rx_empty", 64'(rx_empty_o), 64'd1);
      check_eq("rst_tx_level", 64'(tx_level_o), 64'd0);
      check_eq("rst_rx_level", 64'(rx_level_o), 64'd0);
      check_eq("rst_start",    64'(m_if.start_o), 64'd0);
      check_eq("rst_busy",     64'(busy_o), 64'd0);
      check_eq("rst_flags",    64'({tx_full_o, tx_ovf_o, rx_ovf_o, start_err_o, irq_o}), 64'd0);
      check_eq("rst_rx_data",  64'(rx_data_o), 64'd0);
      check_eq("rst_mosi",     64'(m_if.mosi_data_o), 64'd0);

      RST = 1'b0;
      word_len_i = 2'd3; spi_mode_i = 2'd1; en_i = 1'b1;
      ifg_i = 8'h11; cs_sck_i = 8'h22; sck_cs_i = 8'h33; sck_speed_i = 2'd2;
      @(negedge GCLK);

      // Single word: start two cycles after the push, RX word two cycles after busy falls
      push_tx(32'hA5A5_1234, 32'hDEAD_BEEF, 1'b1, 1'b1);
      check_eq("start_n1", 64'(m_if.start_o), 64'd0);
      @(negedge GCLK);
      check_eq("start_n2",   64'(m_if.start_o), 64'd1);
      check_eq("mode_n2",    64'(m_if.spi_mode_o), 64'd1);
      check_eq("mosi_n2",    64'(m_if.mosi_data_o), 64'hA5A5_1234);
      check_eq("wlen_n2",    64'(m_if.word_len_o), 64'd3);
      check_eq("ifg_n2",     64'({m_if.ifg_o, m_if.cs_sck_o, m_if.sck_cs_o}), 64'h11_2233);
      @(negedge GCLK);
      check_eq("start_pulse", 64'(m_if.start_o), 64'd0);
      for (int t = 0; t < 64 && rx_empty_o; t++) @(negedge GCLK);
      check_eq("rx_latency", 64'(cyc - fall_cyc), 64'd2);
      check_eq("rx_level1",  64'(rx_level_o), 64'd1);
      drain_rx(1);
      wait_idle("idle_single");

      // Masking to one byte
      word_len_i = 2'd0;
      push_tx(32'h1234_5678, 32'hFFFF_FF3C, 1'b1, 1'b1);
      wait_idle("idle_mask");
      drain_rx(1);

      // Config shadowing across a live change
      word_len_i = 2'd3; spi_mode_i = 2'd0; hold_cyc = 6;
      push_tx(32'h0BAD_F00D, 32'h0102_0304, 1'b1, 1'b1);
      wait_master_busy("busy_shadow");
      spi_mode_i = 2'd3;
      @(negedge GCLK);
      check_eq("shadow_mid", 64'(m_if.spi_mode_o), 64'd0);
      wait_idle("idle_shadow");
      check_eq("shadow_after", 64'(m_if.spi_mode_o), 64'd0);
      push_tx(32'hCAFE_0001, 32'h8765_4321, 1'b1, 1'b1);
      wait_start("start_shadow2");
      check_eq("shadow_next", 64'(m_if.spi_mode_o), 64'd3);
      wait_idle("idle_shadow2");
      drain_rx(2);

      // TX and RX overflow
      hold_cyc = 2; en_i = 1'b0;
      for (int i = 0; i < 10; i++)
         push_tx(32'h1000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i), i < 8, i < 8);
      check_eq("ovf_tx_level", 64'(tx_level_o), 64'd8);
      check_eq("ovf_tx_full",  64'(tx_full_o), 64'd1);
      check_eq("ovf_tx_flag",  64'(tx_ovf_o), 64'd1);
      check_eq("ovf_busy",     64'(busy_o), 64'd1);
      en_i = 1'b1;
      wait_idle("idle_ovf8");
      check_eq("ovf_rx_level8", 64'(rx_level_o), 64'd8);
      check_eq("ovf_rx_clear",  64'(rx_ovf_o), 64'd0);
      push_tx(32'h2000_0000, 32'hC0DE_00FF, 1'b1, 1'b0);
      wait_idle("idle_ovf9");
      check_eq("ovf_rx_flag",   64'(rx_ovf_o), 64'd1);
      check_eq("ovf_rx_level9", 64'(rx_level_o), 64'd8);
      drain_rx(8);
      check_eq("ovf_drained", 64'(rx_empty_o), 64'd1);
      do_flush();
      check_eq("flush_flags", 64'({tx_ovf_o, rx_ovf_o}), 64'd0);

      // Start timeout: master never answers
      model_en = 1'b0;
      push_tx(32'h3333_3333, 32'h0, 1'b0, 1'b0);
      wait_start("start_to");
      repeat (14) @(negedge GCLK);
      check_eq("to_early", 64'(start_err_o), 64'd0);
      @(negedge GCLK);
      check_eq("to_err",      64'(start_err_o), 64'd1);
      check_eq("to_idle",     64'(busy_o), 64'd0);
      check_eq("to_rx_level", 64'(rx_level_o), 64'd0);
      model_en = 1'b1;
      do_flush();
      check_eq("to_flush", 64'(start_err_o), 64'd0);
      check_eq("irq_idle", 64'(irq_o), 64'(EXP_IRQ_IDLE));

      // Flush mid-transfer with three words still queued
      hold_cyc = 8; en_i = 1'b0;
      push_tx(32'h4444_0001, 32'h5555_AAAA, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) push_tx(32'h4444_0010 + 32'(i), 32'h0, 1'b0, 1'b0);
      check_eq("fl_tx_level4", 64'(tx_level_o), 64'd4);
      en_i = 1'b1;
      wait_master_busy("busy_flush");
      @(negedge GCLK);
      do_flush();
      check_eq("fl_tx_level0", 64'(tx_level_o), 64'd0);
      check_eq("fl_rx_level0", 64'(rx_level_o), 64'd0);
      wait_idle("idle_flush");
      check_eq("fl_rx_level1", 64'(rx_level_o), 64'd1);
      drain_rx(1);

      // Reset in the middle of a transfer
      spi_mode_i = 2'd3;
      push_tx(32'h6666_6666, 32'h7777_7777, 1'b1, 1'b0);
      wait_master_busy("busy_rst");
      @(negedge GCLK);
      RST = 1'b1;
      @(negedge GCLK);
      check_eq("mrst_start",    64'(m_if.start_o), 64'd0);
      check_eq("mrst_busy",     64'(busy_o), 64'd0);
      check_eq("mrst_rx_empty", 64'(rx_empty_o), 64'd1);
      check_eq("mrst_levels",   64'({tx_level_o, rx_level_o}), 64'd0);
      check_eq("mrst_mode",     64'(m_if.spi_mode_o), 64'd0);
      check_eq("mrst_mosi",     64'(m_if.mosi_data_o), 64'd0);
      repeat (2) @(negedge GCLK);
      RST = 1'b0;
      repeat (3) @(negedge GCLK);
      check_eq("end_empty", 64'(rx_empty_o), 64'd1);
      check_eq("end_irq",   64'(irq_o), 64'(EXP_IRQ_IDLE));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
